// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache front end: zero-latency hit lookup,
// four-word line refill from backing memory, flush and hit/miss counters.
module icache_fetch #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] fetch_addr,
  input  logic        fetch_req,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        stall,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int IW = $clog2(LINES);
  localparam int OW = $clog2(WORDS);
  localparam int TW = 30 - OW - IW;
  localparam int LW = 30 - OW;

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [TW-1:0]    r_tag [LINES];
  logic [31:0]      r_data [LINES*WORDS];
  logic [LINES-1:0] r_valid;
  logic [LW-1:0]    r_line;
  logic [OW-1:0]    r_cnt;
  logic [15:0]      r_hits;
  logic [15:0]      r_miss;

  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic [OW-1:0] w_off;
  logic [IW-1:0] w_fidx;
  logic [TW-1:0] w_ftag;
  logic          w_lookup;
  logic          w_hit;
  logic          w_start;
  logic          w_fill;
  logic          w_acc;
  logic          w_last;

  assign w_off  = fetch_addr[OW-1:0];
  assign w_idx  = fetch_addr[OW +: IW];
  assign w_tag  = fetch_addr[29 -: TW];
  assign w_fidx = r_line[IW-1:0];
  assign w_ftag = r_line[LW-1 -: TW];

  // Lookup only in IDLE; reset and flush mask any hit.
  assign w_lookup = reset & fetch_req & ~flush
                  & (r_state == S_IDLE);
  assign w_hit    = w_lookup & r_valid[w_idx]
                  & (r_tag[w_idx] == w_tag);
  assign w_start  = w_lookup & ~w_hit;
  assign w_fill   = reset & (r_state == S_FILL);
  assign w_acc    = w_fill & ~flush & mem_ready;
  assign w_last   = w_acc & (r_cnt == OW'(WORDS-1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_start) w_next = S_FILL;
      S_FILL: if (flush || w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign inst       = r_data[{w_idx, w_off}];
  assign inst_valid = w_hit;
  assign stall      = fetch_req & ~w_hit;
  assign mem_req    = w_fill;
  assign mem_addr   = w_fill ? {r_line, r_cnt} : '0;
  assign hit_count  = r_hits;
  assign miss_count = r_miss;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_cnt   <= '0;
      r_hits  <= '0;
      r_miss  <= '0;
    end else begin
      r_state <= w_next;
      if (w_hit && r_hits != 16'hFFFF)
        r_hits <= r_hits + 16'd1;
      if (flush) begin
        r_valid <= '0;
        r_cnt   <= '0;
      end
      if (w_start) begin
        r_cnt          <= '0;
        r_valid[w_idx] <= 1'b0;
        if (r_miss != 16'hFFFF)
          r_miss <= r_miss + 16'd1;
      end
      if (w_acc) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_last) r_valid[w_fidx] <= 1'b1;
      end
    end
  end

  // Tag, data and captured line need no reset.
  always_ff @(posedge clock) begin
    if (w_start) r_line <= fetch_addr[29:OW];
    if (w_acc) r_data[{w_fidx, r_cnt}] <= mem_data;
    if (w_last) r_tag[w_fidx] <= w_ftag;
  end

endmodule
